// File: rtl/bsg_wormhole_router_generic.sv
// Parametrised wormhole router for 1D (P,W,E) or 2D (P,W,E,N,S) meshes.
// Each input has a FIFO plus route state. Each output runs a round-robin
// IDLE/LOCKED arbiter that holds the output for the whole packet.
// Misrouted packets are dropped, and err_o is set sticky for that input.
// Optional macro BSG_WORMHOLE_ROUTER_PERF_EN adds 16-bit saturating
// per-output header counters on perf_pkt_cnt_o.

// Per-input FIFO, header decode and packet tracking.
module bsg_wormhole_router_input #(
    parameter int flit_width_p   = 32,
    parameter int x_cord_width_p = 4,
    parameter int y_cord_width_p = 4,
    parameter int len_width_p    = 4,
    parameter int dims_p         = 2,
    parameter int yx_route_p     = 0,
    parameter int fifo_els_p     = 2,
    parameter int dirs_p         = 5,
    parameter int port_p         = 0,
    parameter bit loopback_p     = 1'b0,
    parameter bit stub_p         = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      v_i,
    input  logic [flit_width_p-1:0]   data_i,
    output logic                      ready_o,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    input  logic                      deq_i,
    output logic                      hdr_v_o,
    output logic                      body_v_o,
    output logic [dirs_p-1:0]         dest_o,
    output logic [flit_width_p-1:0]   data_o,
    output logic [len_width_p-1:0]    len_o,
    output logic                      err_o
);
    localparam int ptr_w_lp   = $clog2(fifo_els_p);
    localparam int cnt_w_lp   = $clog2(fifo_els_p + 1);
    localparam int len_off_lp = x_cord_width_p + ((dims_p == 2) ? y_cord_width_p : 0);

    logic [fifo_els_p-1:0][flit_width_p-1:0] mem_r;
    logic [ptr_w_lp-1:0]    rd_r, wr_r;
    logic [cnt_w_lp-1:0]    cnt_r;
    logic [len_width_p-1:0] in_cnt_r;
    logic [dirs_p-1:0]      dest_r, dec;
    logic [4:0]             dec5;
    logic                   drop_r, err_r;
    logic                   valid, full, hdr, mis, enq, deq;
    logic [x_cord_width_p-1:0] x;
    logic [y_cord_width_p-1:0] y;

    assign data_o  = mem_r[rd_r];
    assign x       = data_o[x_cord_width_p-1:0];
    assign y       = data_o[x_cord_width_p +: y_cord_width_p];
    assign len_o   = data_o[len_off_lp +: len_width_p];
    assign valid   = (cnt_r != '0);
    assign full    = (cnt_r == cnt_w_lp'(fifo_els_p));
    assign hdr     = (in_cnt_r == '0);
    // ready is held low through reset; a stubbed input swallows everything
    assign ready_o = stub_p ? 1'b1 : (~reset_i & ~full);
    assign enq     = v_i & ~full & ~reset_i & ~stub_p;
    assign dec     = dec5[dirs_p-1:0];
    assign mis     = dec5[port_p] & ~loopback_p;
    // misrouted headers and their body flits drain themselves, unrouted
    assign deq     = valid & (deq_i | (hdr ? mis : drop_r));
    assign hdr_v_o  = valid & hdr & ~mis;
    assign body_v_o = valid & ~hdr & ~drop_r;
    assign dest_o   = hdr ? dec : dest_r;
    assign err_o    = err_r;

    // dimension-ordered route decode of the head flit (P=0,W=1,E=2,N=3,S=4)
    always_comb begin
        dec5 = 5'b00001;
        if (dims_p == 1) begin
            if (x < my_x_i)      dec5 = 5'b00010;
            else if (x > my_x_i) dec5 = 5'b00100;
        end else if (yx_route_p != 0) begin
            if (y < my_y_i)      dec5 = 5'b01000;
            else if (y > my_y_i) dec5 = 5'b10000;
            else if (x < my_x_i) dec5 = 5'b00010;
            else if (x > my_x_i) dec5 = 5'b00100;
        end else begin
            if (x < my_x_i)      dec5 = 5'b00010;
            else if (x > my_x_i) dec5 = 5'b00100;
            else if (y < my_y_i) dec5 = 5'b01000;
            else if (y > my_y_i) dec5 = 5'b10000;
        end
    end

    // FIFO storage, no reset needed since validity lives in cnt_r
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wr_r] <= data_i;
    end

    // FIFO pointers and packet state: in_cnt counts body flits left
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_r     <= '0;
            wr_r     <= '0;
            cnt_r    <= '0;
            in_cnt_r <= '0;
            dest_r   <= '0;
            drop_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            if (enq) wr_r <= (wr_r == ptr_w_lp'(fifo_els_p - 1)) ? '0 : wr_r + ptr_w_lp'(1);
            if (deq) rd_r <= (rd_r == ptr_w_lp'(fifo_els_p - 1)) ? '0 : rd_r + ptr_w_lp'(1);
            cnt_r <= cnt_r + cnt_w_lp'(enq) - cnt_w_lp'(deq);
            if (deq) begin
                if (hdr) begin
                    in_cnt_r <= len_o;
                    dest_r   <= dec;
                    drop_r   <= mis;
                    if (mis) err_r <= 1'b1;
                end else begin
                    in_cnt_r <= in_cnt_r - len_width_p'(1);
                end
            end
        end
    end
endmodule

// Per-output round-robin arbiter that holds the output for one packet.
module bsg_wormhole_router_output #(
    parameter int dirs_p      = 5,
    parameter int len_width_p = 4,
    localparam int sel_w_lp   = $clog2(dirs_p)
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [dirs_p-1:0]                   hdr_req_i,
    input  logic [dirs_p-1:0]                   body_v_i,
    input  logic [dirs_p-1:0][len_width_p-1:0]  len_i,
    input  logic                                ready_i,
    output logic                                v_o,
    output logic [sel_w_lp-1:0]                 sel_o,
    output logic                                xfer_o,
    output logic                                hdr_xfer_o
);
    typedef enum logic {e_idle, e_locked} state_e;

    state_e                 state_r, state_n;
    logic [sel_w_lp-1:0]    owner_r, owner_n, rr_r, rr_n, grant;
    logic [len_width_p-1:0] cnt_r, cnt_n;
    logic                   found;

    function automatic logic [sel_w_lp-1:0] rr_idx(input logic [sel_w_lp-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= dirs_p) s = s - dirs_p;
        return sel_w_lp'(s);
    endfunction

    // arbitration and lock tracking; v_o uses only registered state
    always_comb begin
        found   = 1'b0;
        grant   = '0;
        state_n = state_r;
        owner_n = owner_r;
        cnt_n   = cnt_r;
        rr_n    = rr_r;
        for (int k = 0; k < dirs_p; k++) begin
            if (!found && hdr_req_i[rr_idx(rr_r, k)]) begin
                found = 1'b1;
                grant = rr_idx(rr_r, k);
            end
        end
        v_o        = (state_r == e_idle) ? found : body_v_i[owner_r];
        sel_o      = (state_r == e_idle) ? grant : owner_r;
        xfer_o     = v_o & ready_i;
        hdr_xfer_o = xfer_o & (state_r == e_idle);
        case (state_r)
            e_idle: if (xfer_o) begin
                rr_n = rr_idx(grant, 1);
                if (len_i[grant] != '0) begin
                    state_n = e_locked;
                    owner_n = grant;
                    cnt_n   = len_i[grant];
                end
            end
            default: if (xfer_o) begin
                cnt_n = cnt_r - len_width_p'(1);
                if (cnt_r == len_width_p'(1)) state_n = e_idle;
            end
        endcase
    end

    // arbiter state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_idle;
            owner_r <= '0;
            rr_r    <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            owner_r <= owner_n;
            rr_r    <= rr_n;
            cnt_r   <= cnt_n;
        end
    end
endmodule

module bsg_wormhole_router_generic #(
    parameter int flit_width_p   = 32,
    parameter int x_cord_width_p = 4,
    parameter int y_cord_width_p = 4,
    parameter int len_width_p    = 4,
    parameter int dims_p         = 2,
    parameter int yx_route_p     = 0,
    parameter int fifo_els_p     = 2,
    localparam int dirs_lp       = (dims_p == 1) ? 3 : 5,
    parameter logic [dirs_lp-1:0] loopback_mask_p = '0,
    parameter logic [dirs_lp-1:0] stub_in_p       = '0,
    parameter logic [dirs_lp-1:0] stub_out_p      = '0
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [dirs_lp-1:0]                   v_i,
    input  logic [dirs_lp-1:0][flit_width_p-1:0] data_i,
    output logic [dirs_lp-1:0]                   ready_o,
    output logic [dirs_lp-1:0]                   v_o,
    output logic [dirs_lp-1:0][flit_width_p-1:0] data_o,
    input  logic [dirs_lp-1:0]                   ready_i,
    input  logic [x_cord_width_p-1:0]            my_x_i,
    input  logic [y_cord_width_p-1:0]            my_y_i,
    output logic [dirs_lp-1:0]                   err_o
`ifdef BSG_WORMHOLE_ROUTER_PERF_EN
   ,output logic [dirs_lp-1:0][15:0]             perf_pkt_cnt_o
`endif
);
    localparam int sel_w_lp = $clog2(dirs_lp);
    // the local port may always loop back to itself
    localparam logic [dirs_lp-1:0] lb_mask_lp = loopback_mask_p | dirs_lp'(1);

    logic [dirs_lp-1:0]                   hdr_v, body_v, deq, xfer, hdr_xfer;
    logic [dirs_lp-1:0][dirs_lp-1:0]      dest, hdr_req, body_req;
    logic [dirs_lp-1:0][flit_width_p-1:0] in_data;
    logic [dirs_lp-1:0][len_width_p-1:0]  in_len;
    logic [dirs_lp-1:0][sel_w_lp-1:0]     sel;

    for (genvar i = 0; i < dirs_lp; i++) begin : g_in
        bsg_wormhole_router_input #(
            .flit_width_p(flit_width_p), .x_cord_width_p(x_cord_width_p),
            .y_cord_width_p(y_cord_width_p), .len_width_p(len_width_p),
            .dims_p(dims_p), .yx_route_p(yx_route_p), .fifo_els_p(fifo_els_p),
            .dirs_p(dirs_lp), .port_p(i), .loopback_p(lb_mask_lp[i]), .stub_p(stub_in_p[i])
        ) in_u (
            .clk_i, .reset_i, .v_i(v_i[i]), .data_i(data_i[i]), .ready_o(ready_o[i]),
            .my_x_i, .my_y_i, .deq_i(deq[i]), .hdr_v_o(hdr_v[i]), .body_v_o(body_v[i]),
            .dest_o(dest[i]), .data_o(in_data[i]), .len_o(in_len[i]), .err_o(err_o[i])
        );
    end

    // transpose input destinations into per-output request vectors
    always_comb begin
        for (int o = 0; o < dirs_lp; o++) begin
            for (int i = 0; i < dirs_lp; i++) begin
                hdr_req[o][i]  = hdr_v[i] & dest[i][o];
                body_req[o][i] = body_v[i] & dest[i][o];
            end
        end
    end

    for (genvar o = 0; o < dirs_lp; o++) begin : g_out
        bsg_wormhole_router_output #(.dirs_p(dirs_lp), .len_width_p(len_width_p)) out_u (
            .clk_i, .reset_i, .hdr_req_i(hdr_req[o]), .body_v_i(body_req[o]), .len_i(in_len),
            .ready_i(ready_i[o] | stub_out_p[o]), .v_o(v_o[o]), .sel_o(sel[o]),
            .xfer_o(xfer[o]), .hdr_xfer_o(hdr_xfer[o])
        );
`ifdef BSG_WORMHOLE_ROUTER_PERF_EN
        // saturating count of headers sent on this output
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) perf_pkt_cnt_o[o] <= '0;
            else if (hdr_xfer[o] && perf_pkt_cnt_o[o] != 16'hFFFF)
                perf_pkt_cnt_o[o] <= perf_pkt_cnt_o[o] + 16'd1;
        end
`endif
    end

    // output data crossbar and dequeue back to the selected input
    always_comb begin
        deq = '0;
        for (int o = 0; o < dirs_lp; o++) begin
            data_o[o] = in_data[sel[o]];
            if (xfer[o]) deq[sel[o]] = 1'b1;
        end
    end
endmodule

// File: tb/tb_bsg_wormhole_router_generic.sv
// Scoreboard bench for bsg_wormhole_router_generic (2D, XY, my=(2,2), 4-deep FIFOs).
module tb_bsg_wormhole_router_generic;
    localparam int D = 5, FW = 32;
    localparam int P = 0, W = 1, E = 2, N = 3, S = 4;

    logic clk = 1'b0, reset = 1'b0;
    logic [D-1:0] v_i = '0, ready_i = '1, ready_o, v_o, err_o;
    logic [D-1:0][FW-1:0] data_i = '0, data_o;
    logic [3:0] my_x = 4'd2, my_y = 4'd2;
    logic [D-1:0] rdy = '1;
`ifdef BSG_WORMHOLE_ROUTER_PERF_EN
    logic [D-1:0][15:0] perf;
`endif

    always #5 clk = ~clk;

    bsg_wormhole_router_generic #(.fifo_els_p(4)) dut (
        .clk_i(clk), .reset_i(reset), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
        .v_o(v_o), .data_o(data_o), .ready_i(ready_i), .my_x_i(my_x), .my_y_i(my_y),
        .err_o(err_o)
`ifdef BSG_WORMHOLE_ROUTER_PERF_EN
       ,.perf_pkt_cnt_o(perf)
`endif
    );

    int total = 0, bad = 0, cyc = 0;
    logic [FW-1:0] inq [D][$];
    logic [FW-1:0] expq [D][$];
    int first_in [D], first_out [D], last_out [D], acc_in [D], del_out [D];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] hdr(input int x, input int y, input int len, input int tag);
        return {tag[19:0], len[3:0], y[3:0], x[3:0]};
    endfunction

    // queue a packet on input src; dst<0 means it must never appear
    task automatic send(input int src, input int dst, input int x, input int y, input int len, input int tag);
        logic [FW-1:0] f;
        f = hdr(x, y, len, tag);
        inq[src].push_back(f);
        if (dst >= 0) expq[dst].push_back(f);
        for (int j = 0; j < len; j++) begin
            f = {tag[15:0], 16'hB000 + 16'(j)};
            inq[src].push_back(f);
            if (dst >= 0) expq[dst].push_back(f);
        end
    endtask

    task automatic clear_track();
        for (int i = 0; i < D; i++) begin
            first_in[i] = -1; first_out[i] = -1; last_out[i] = -1;
            acc_in[i] = 0; del_out[i] = 0;
        end
    endtask

    // one cycle: drive at negedge, check outputs and retire handshakes before posedge
    task automatic step();
        @(negedge clk);
        ready_i = rdy;
        for (int i = 0; i < D; i++) begin
            if (inq[i].size() > 0) begin v_i[i] = 1'b1; data_i[i] = inq[i][0]; end
            else begin v_i[i] = 1'b0; data_i[i] = '0; end
        end
        #1;
        for (int o = 0; o < D; o++) begin
            if (v_o[o] && ready_i[o]) begin
                if (first_out[o] < 0) first_out[o] = cyc;
                last_out[o] = cyc;
                del_out[o]++;
                if (expq[o].size() == 0) chk($sformatf("extra_out%0d", o), 32'(v_o[o]), 32'd0);
                else chk($sformatf("flit_out%0d", o), data_o[o], expq[o].pop_front());
            end
        end
        for (int i = 0; i < D; i++) begin
            if (v_i[i] && ready_o[i]) begin
                if (first_in[i] < 0) first_in[i] = cyc;
                acc_in[i]++;
                void'(inq[i].pop_front());
            end
        end
        cyc++;
    endtask

    task automatic drain(input string tag, input int max);
        int n, pend;
        n = 0;
        pend = 1;
        while (pend != 0 && n < max) begin
            step();
            n++;
            pend = 0;
            for (int i = 0; i < D; i++) pend += inq[i].size() + expq[i].size();
        end
        repeat (3) step();
        chk(tag, 32'(pend), 32'd0);
    endtask

    task automatic wait_out(input string tag, input int o, input int n, input int max);
        int k;
        k = 0;
        while (del_out[o] < n && k < max) begin step(); k++; end
        chk(tag, 32'(del_out[o] >= n), 32'd1);
    endtask

    // asynchronous reset, asserted away from any clock edge
    task automatic do_reset();
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        chk("rst_v_o", 32'(v_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd0);
        chk("rst_err_o", 32'(err_o), 32'd0);
        for (int i = 0; i < D; i++) begin inq[i].delete(); expq[i].delete(); end
        v_i = '0;
        rdy = '1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_ready_o", 32'(ready_o), 32'h1f);
        clear_track();
    endtask

    initial begin
        clear_track();
        do_reset();

        // W -> E, 3 flits back to back, one cycle after enqueue
        send(W, E, 3, 0, 2, 1);
        drain("t1_drain", 40);
        chk("t1_latency", 32'(first_out[E]), 32'(first_in[W] + 1));
        chk("t1_contig", 32'(last_out[E] - first_out[E]), 32'd2);
        chk("t1_err", 32'(err_o), 32'd0);
`ifdef BSG_WORMHOLE_ROUTER_PERF_EN
        chk("t1_perf", 32'(perf[E]), 32'd1);
`endif

        // header-only P -> N, then S -> N granted the very next cycle
        clear_track();
        send(P, N, 2, 1, 0, 2);
        send(S, N, 2, 0, 0, 3);
        drain("t2_drain", 40);
        chk("t2_first", 32'(first_out[N]), 32'(first_in[P] + 1));
        chk("t2_next", 32'(last_out[N]), 32'(first_out[N] + 1));

        // W and S contend for P: whole packets, RR alternates W,S,W,S
        do_reset();
        send(W, P, 2, 2, 3, 4);
        send(S, P, 2, 2, 3, 5);
        send(W, P, 2, 2, 3, 6);
        send(S, P, 2, 2, 3, 7);
        drain("t3_drain", 80);
        chk("t3_cnt", 32'(del_out[P]), 32'd16);

        // backpressure on E mid-packet with 4-deep FIFO
        do_reset();
        send(W, E, 5, 2, 9, 8);
        wait_out("t4_start", E, 2, 40);
        rdy[E] = 1'b0;
        repeat (10) step();
        chk("t4_ready_low", 32'(ready_o[W]), 32'd0);
        chk("t4_buffered", 32'(acc_in[W] - del_out[E]), 32'd4);
        rdy[E] = 1'b1;
        drain("t4_drain", 60);
        chk("t4_total", 32'(del_out[E]), 32'd10);

        // E input routes back to E without loopback: dropped, sticky error
        do_reset();
        send(E, -1, 3, 2, 5, 9);
        drain("t5_drain", 40);
        chk("t5_consumed", 32'(acc_in[E]), 32'd6);
        chk("t5_err", 32'(err_o), 32'h04);
        repeat (5) step();
        chk("t5_err_sticky", 32'(err_o), 32'h04);
        send(W, E, 3, 2, 0, 10);
        drain("t5_after", 40);
        chk("t5_err_hold", 32'(err_o), 32'h04);

        // async reset mid-packet, then fresh headers route correctly
        do_reset();
        send(W, E, 4, 2, 9, 11);
        wait_out("t6_start", E, 3, 40);
        do_reset();
        send(W, S, 2, 3, 1, 12);
        send(P, E, 7, 2, 0, 13);
        drain("t6_drain", 40);
        chk("t6_s", 32'(del_out[S]), 32'd2);
        chk("t6_e", 32'(del_out[E]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bsg_wormhole_router_generic.md
Name: bsg_wormhole_router_generic

Overview:
Parametrised next-generation wormhole router for 1D (P/W/E) or 2D (P/W/E/N/S) meshes, using dimension-ordered XY or YX routing.
- Generalises the existing router with configurable input buffer depth and a per-port loopback policy.
- Discards misrouted packets, flagging them with a sticky error.
- Sits at every mesh tile between the local endpoint and neighbouring routers, using the standard valid/ready link handshake.

Parameters:
- flit_width_p, 32, flit width in bits; must be ≥ x_cord_width_p+y_cord_width_p+len_width_p.
- x_cord_width_p, 4, X coordinate width.
- y_cord_width_p, 4, Y coordinate width; ignored when dims_p=1.
- len_width_p, 4, body-flit count field width.
- dims_p, 2, 1 gives dirs=3 (P,W,E); 2 gives dirs=5 (P,W,E,N,S).
- yx_route_p, 0, 0 routes X then Y; 1 routes Y then X.
- fifo_els_p, 2, input FIFO depth per port; must be ≥2.
- loopback_mask_p, {dirs{1'b0}} with bit P forced to 1, bit i=1 allows input i to route to output i.
- stub_in_p, 0, per-port input stub; the stubbed input always has ready_o=1, and its data is never presented.
- stub_out_p, 0, per-port output stub; the stubbed output is treated as always ready.

Ports:
- clk_i, in, 1, clock.
- reset_i, in, 1, asynchronous active-high reset.
- v_i, in, dirs, per-port input valid.
- data_i, in, dirs*flit_width_p, per-port input flit.
- ready_o, out, dirs, per-port input ready (FIFO not full).
- v_o, out, dirs, per-port output valid.
- data_o, out, dirs*flit_width_p, per-port output flit.
- ready_i, in, dirs, per-port downstream ready.
- my_x_i, in, x_cord_width_p, local X coordinate.
- my_y_i, in, y_cord_width_p, local Y coordinate.
- err_o, out, dirs, sticky per-input misroute flag.

Behaviour:
- One clock clk_i; reset_i is asynchronous, active-high. Reset clears all FIFOs, counters, locks and arbiter pointers. During reset: v_o=0, ready_o=0 (stubs: 1), err_o=0.
- Header flit layout, LSB first: x_cord, then y_cord (present only when dims_p=2), then len. len = number of body flits after the header; len=0 is a header-only packet.
- Transfer rules:
  - Input transfer occurs on v_i & ready_o.
  - Output transfer occurs on v_o & (ready_i | stub_out_p).
  - v_o never depends combinationally on ready_i.
- Per-input route state:
  - in_cnt is 0 at a packet boundary.
  - When in_cnt==0, the FIFO head is a header: decode destination one-hot, latch it into dest_r, load in_cnt=len on dequeue.
  - When in_cnt>0, dest_r is held and in_cnt decrements on each dequeue.
- Route decode:
  - XY: x<my_x→W; x>my_x→E; else y<my_y→N; y>my_y→S; else P.
  - YX: the same, with the dimensions swapped.
  - 1D: X comparison only.
- Per-output FSM, IDLE/LOCKED:
  - IDLE: round-robin arbitration among inputs whose head is a header targeting this output. Grant and header transfer happen in the same cycle as output ready (zero bubble).
  - On header transfer with len>0, go to LOCKED with owner=winner and out_cnt=len. With len=0, stay IDLE and advance the RR pointer.
  - LOCKED: only the owner's flits pass. out_cnt decrements per transfer; on the transfer where out_cnt==1, return to IDLE. Other requesters stall.
  - RR pointer advances past the winner on each header grant only.
- Latency: a flit arriving at an empty FIFO appears at v_o on the next cycle (FIFO registered output). Throughput is 1 flit/cycle/port.
- Full/empty:
  - ready_o=0 when the FIFO holds fifo_els_p flits.
  - Simultaneous enqueue and dequeue on a full FIFO is not allowed; ready_o stays low that cycle.
- Misroute: a header whose decoded output equals its input port and loopback_mask_p[i]=0.
  - The whole packet (header+len body flits) is dequeued at 1 flit/cycle and dropped.
  - err_o[i] is set and stays set until reset.
- Simultaneous events:
  - Multiple headers to the same IDLE output: exactly one wins per cycle.
  - One input never drives two outputs.
- Width: counters are len_width_p bits; len = 2^len_width_p−1 must work without wrap.

Optional Feature:
- Macro: BSG_WORMHOLE_ROUTER_PERF_EN.
- Defined: adds output port perf_pkt_cnt_o (dirs*16, one count per output). Each count is a 16-bit saturating counter of header flits sent on that output; cleared by reset; holds at 16'hFFFF.
- Undefined: the port and counters are absent, and behaviour is otherwise identical.

Test Plan:
- dims_p=2, XY, my=(2,2): header x=3,y=0,len=2 on W → 3 flits on E in consecutive cycles, first at cycle 1 after enqueue; err_o=0.
- Header x=2,y=1,len=0 on P → single flit on N; N output stays IDLE; a following packet from S to N is granted next cycle.
- W and S both send len=3 to P simultaneously → one packet's 4 flits contiguous, then the other's; no interleave. The RR winner alternates on a repeat.
- Hold ready_i[E]=0 for 10 cycles mid-packet with fifo_els_p=4 → ready_o[W] drops after 4 buffered flits; no flit loss or duplication on release.
- Input E sends header x=3 (routes E) with loopback_mask_p[E]=0, len=5 → 6 flits consumed, none output, err_o[E]=1 until reset.
- Assert reset_i asynchronously mid-packet → v_o=0 immediately; the next header after reset routes correctly with in_cnt=0.
